// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and default sizing for the writeback port arbiter
package wb_port_arbiter_pkg;
   localparam int WBARB_DATA_W       = 32;
   localparam int WBARB_REG_ADDR_W   = 5;
   localparam int WBARB_FIFO_DEPTH   = 4;
   localparam int WBARB_STARVE_LIMIT = 8;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: buffered long-latency results with per-entry live bits and parallel address compares
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W     = WBARB_DATA_W,
   parameter int REG_ADDR_W = WBARB_REG_ADDR_W,
   parameter int DEPTH      = WBARB_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   input  logic                  kill,
   input  logic [REG_ADDR_W-1:0] kill_addr,
   input  logic [REG_ADDR_W-1:0] hz_addr,
   output logic                  empty,
   output logic                  full,
   output logic                  head_live,
   output logic [REG_ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0]     head_data,
   output logic                  hz_match
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [REG_ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0]      live_q, kill_hit, hz_hit;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count;
   assign empty     = count == '0;
   assign full      = count == (PTR_W+1)'(DEPTH);
   assign head_live = live_q[rd_ptr];
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign hz_match  = |hz_hit;
   // compare every live entry against the kill and lookup addresses in parallel
   always_comb begin
      kill_hit = '0;
      hz_hit   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_hit[i] = live_q[i] && addr_q[i] == kill_addr;
         hz_hit[i]   = live_q[i] && addr_q[i] == hz_addr;
      end
   end
   // storage and pointers; a same-cycle push lands after the kill so it stays live
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         live_q <= '0;
      end else begin
         if (kill) live_q <= live_q & ~kill_hit;
         if (pop) begin
            live_q[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            live_q[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between pipeline writeback and buffered long-latency results
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W       = WBARB_DATA_W,
   parameter int REG_ADDR_W   = WBARB_REG_ADDR_W,
   parameter int FIFO_DEPTH   = WBARB_FIFO_DEPTH,
   parameter int STARVE_LIMIT = WBARB_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_wr,
   input  logic [REG_ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0]     pipe_data,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_addr,
   input  logic [DATA_W-1:0]     lu_data,
   output logic                  stall_req,
   output logic                  regfile_wr,
   output logic [REG_ADDR_W-1:0] regfile_addr_wr,
   output logic [DATA_W-1:0]     regfile_data_wr,
   input  logic [REG_ADDR_W-1:0] hz_addr,
   output logic                  hz_pending
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   logic                  push, pop, empty, full, head_live, hz_match, stall_d;
   logic [REG_ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0]     head_data;
   logic [CNT_W-1:0]      starve_q, starve_d;
   // writes to r0 are handshaken but never buffered
   assign lu_ready = !full;
   assign push     = lu_valid && lu_ready && lu_addr != '0;
   assign pop      = !pipe_wr && !empty;
   wb_result_fifo #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (lu_addr),
      .push_data (lu_data),
      .pop       (pop),
      .kill      (pipe_wr && pipe_addr != '0),
      .kill_addr (pipe_addr),
      .hz_addr   (hz_addr),
      .empty     (empty),
      .full      (full),
      .head_live (head_live),
      .head_addr (head_addr),
      .head_data (head_data),
      .hz_match  (hz_match)
   );
   // pipeline owns the port; a killed head drains without writing
   always_comb begin
      regfile_wr      = pipe_wr || (pop && head_live);
      regfile_addr_wr = pipe_wr ? pipe_addr : head_addr;
      regfile_data_wr = pipe_wr ? pipe_data : head_data;
      hz_pending      = hz_addr != '0 && (hz_match || (push && lu_addr == hz_addr));
      starve_d        = (empty || pop) ? '0 : (starve_q == LIMIT ? starve_q : starve_q + CNT_W'(1));
      stall_d         = !pop && !empty && (stall_req || starve_d == LIMIT);
   end
   // starvation counter and the registered stall request it raises
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q  <= '0;
         stall_req <= 1'b0;
      end else begin
         starve_q  <= starve_d;
         stall_req <= stall_d;
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for the writeback port arbiter
module tb_wb_port_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        pipe_wr = 1'b0, lu_valid = 1'b0;
   logic [4:0]  pipe_addr = '0, lu_addr = '0, hz_addr = '0;
   logic [31:0] pipe_data = '0, lu_data = '0;
   logic        lu_ready, stall_req, regfile_wr, hz_pending;
   logic [4:0]  regfile_addr_wr;
   logic [31:0] regfile_data_wr;
   logic [31:0] rf [32];
   int          tests = 0, fails = 0;

   wb_port_arbiter dut (
      .clk(clk), .rst(rst), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .stall_req(stall_req), .regfile_wr(regfile_wr), .regfile_addr_wr(regfile_addr_wr),
      .regfile_data_wr(regfile_data_wr), .hz_addr(hz_addr), .hz_pending(hz_pending)
   );

   always #5 clk = ~clk;

   // register file as seen through the write port
   always @(posedge clk) if (regfile_wr) rf[regfile_addr_wr] <= regfile_data_wr;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; hz_addr = 5'd5;
      tick; tick;
      rst = 1'b0; #1;
      tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", lu_ready); end
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL reset_hz: got %b want 0", hz_pending); end
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b want 0", regfile_wr); end
   endtask

   task automatic test_basic;
      tick;
      lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hAAAA0001; #1;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL basic_idle: got %b want 0", regfile_wr); end
      tests++; if (hz_pending !== 1'b1) begin fails++; $display("FAIL basic_hz_push: got %b want 1", hz_pending); end
      tick;
      lu_valid = 1'b0; #1;
      tests++; if ({regfile_wr, regfile_addr_wr, regfile_data_wr} !== {1'b1, 5'd5, 32'hAAAA0001}) begin
         fails++; $display("FAIL basic_write: got %b/%0d/%h want 1/5/aaaa0001", regfile_wr, regfile_addr_wr, regfile_data_wr);
      end
      tick; #1;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL basic_empty: got %b want 0", regfile_wr); end
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL basic_hz_clear: got %b want 0", hz_pending); end
   endtask

   task automatic test_starve;
      pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33; lu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lu_addr = 5'(6 + i); lu_data = 32'h600 + 32'(6 + i); #1;
         tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL starve_ready_%0d: got %b want 1", i, lu_ready); end
         tests++; if (regfile_addr_wr !== 5'd3) begin fails++; $display("FAIL starve_pipe_%0d: got %0d want 3", i, regfile_addr_wr); end
         tick;
      end
      lu_valid = 1'b0; #1;
      tests++; if (lu_ready !== 1'b0) begin fails++; $display("FAIL starve_full: got %b want 0", lu_ready); end
      for (int k = 5; k <= 9; k++) begin
         tick;
         tests++; if (stall_req !== (k == 9)) begin fails++; $display("FAIL starve_stall_%0d: got %b want %b", k, stall_req, k == 9); end
      end
      pipe_wr = 1'b0; #1;
      tests++; if ({regfile_wr, regfile_addr_wr, regfile_data_wr} !== {1'b1, 5'd6, 32'h606}) begin
         fails++; $display("FAIL starve_drain: got %b/%0d/%h want 1/6/606", regfile_wr, regfile_addr_wr, regfile_data_wr);
      end
      tick;
      tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_release: got %b want 0", stall_req); end
      for (int i = 7; i <= 9; i++) begin
         tests++; if (regfile_addr_wr !== 5'(i) || regfile_wr !== 1'b1) begin
            fails++; $display("FAIL starve_rest_%0d: got %b/%0d want 1/%0d", i, regfile_wr, regfile_addr_wr, i);
         end
         tick;
      end
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL starve_done: got %b want 0", regfile_wr); end
   endtask

   task automatic test_kill;
      pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33;
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h11; hz_addr = 5'd7; #1;
      tests++; if (hz_pending !== 1'b1) begin fails++; $display("FAIL kill_hz_push: got %b want 1", hz_pending); end
      tick;
      lu_valid = 1'b0; pipe_addr = 5'd7; pipe_data = 32'h22; #1;
      tests++; if (hz_pending !== 1'b1) begin fails++; $display("FAIL kill_hz_live: got %b want 1", hz_pending); end
      tick;
      pipe_wr = 1'b0; #1;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL kill_silent_pop: got %b want 0", regfile_wr); end
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL kill_hz_dead: got %b want 0", hz_pending); end
      tick; tick;
      tests++; if (rf[7] !== 32'h22) begin fails++; $display("FAIL kill_r7: got %h want 22", rf[7]); end
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL kill_no_write: got %b want 0", regfile_wr); end
   endtask

   task automatic test_zero;
      lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hFF; hz_addr = 5'd0; #1;
      tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL zero_ready: got %b want 1", lu_ready); end
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL zero_hz: got %b want 0", hz_pending); end
      tick;
      lu_valid = 1'b0; #1;
      tests++; if (dut.u_fifo.count !== 3'd0) begin fails++; $display("FAIL zero_count: got %0d want 0", dut.u_fifo.count); end
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL zero_write: got %b want 0", regfile_wr); end
      tick;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL zero_write2: got %b want 0", regfile_wr); end
   endtask

   task automatic test_back_to_back;
      pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33; lu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lu_addr = 5'(20 + i); lu_data = 32'h200 + 32'(20 + i);
         tick;
      end
      pipe_wr = 1'b0; lu_addr = 5'd24; lu_data = 32'h224; #1;
      tests++; if (lu_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: got %b want 0", lu_ready); end
      tests++; if ({regfile_wr, regfile_addr_wr, regfile_data_wr} !== {1'b1, 5'd20, 32'h214}) begin
         fails++; $display("FAIL b2b_head: got %b/%0d/%h want 1/20/214", regfile_wr, regfile_addr_wr, regfile_data_wr);
      end
      tick;
      tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", lu_ready); end
      tests++; if (dut.u_fifo.count !== 3'd3) begin fails++; $display("FAIL b2b_count3: got %0d want 3", dut.u_fifo.count); end
      tests++; if (regfile_addr_wr !== 5'd21) begin fails++; $display("FAIL b2b_r21: got %0d want 21", regfile_addr_wr); end
      tick;
      lu_valid = 1'b0; #1;
      tests++; if (dut.u_fifo.count !== 3'd3) begin fails++; $display("FAIL b2b_count_held: got %0d want 3", dut.u_fifo.count); end
      tests++; if (regfile_addr_wr !== 5'd22) begin fails++; $display("FAIL b2b_r22: got %0d want 22", regfile_addr_wr); end
      tick;
      tests++; if (regfile_addr_wr !== 5'd23) begin fails++; $display("FAIL b2b_r23: got %0d want 23", regfile_addr_wr); end
      tick;
      tests++; if ({regfile_wr, regfile_addr_wr, regfile_data_wr} !== {1'b1, 5'd24, 32'h224}) begin
         fails++; $display("FAIL b2b_r24: got %b/%0d/%h want 1/24/224", regfile_wr, regfile_addr_wr, regfile_data_wr);
      end
      tick;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", regfile_wr); end
   endtask

   task automatic test_hazard_reset;
      pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h33;
      lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC0C0; hz_addr = 5'd12; #1;
      tests++; if (hz_pending !== 1'b1) begin fails++; $display("FAIL hz_push: got %b want 1", hz_pending); end
      tick;
      lu_valid = 1'b0; #1;
      tests++; if (hz_pending !== 1'b1) begin fails++; $display("FAIL hz_buffered: got %b want 1", hz_pending); end
      hz_addr = 5'd13; #1;
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL hz_other: got %b want 0", hz_pending); end
      hz_addr = 5'd12;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0; pipe_wr = 1'b0; #1;
      tests++; if (hz_pending !== 1'b0) begin fails++; $display("FAIL hz_after_rst: got %b want 0", hz_pending); end
      tests++; if (lu_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", lu_ready); end
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL rst_no_write: got %b want 0", regfile_wr); end
      tick;
      tests++; if (regfile_wr !== 1'b0) begin fails++; $display("FAIL rst_no_write2: got %b want 0", regfile_wr); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_starve;
      test_kill;
      test_zero;
      test_back_to_back;
      test_hazard_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
- The in-order pipeline writeback (output of the WB stage) always wins the port.
- Long-latency results (multi-cycle mul/div, cache-miss load return) arrive on a valid/ready interface and are buffered in a small FIFO. They drain into port cycles the pipeline leaves idle.
- Also provides a starvation stall request, WAW kill of stale buffered results, and a pending-register lookup for the hazard unit.

Parameters:
- DATA_W, 32, register data width.
- REG_ADDR_W, 5, register address width.
- FIFO_DEPTH, 4, buffered long-latency results; power of two, >=2.
- STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before a stall is requested.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_wr  in  1  pipeline write enable, already gated by flush/stall in the WB stage
- pipe_addr  in  REG_ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept the result
- lu_addr  in  REG_ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result data
- stall_req  out  1  request to the pipeline to freeze so the FIFO head can drain
- regfile_wr  out  1  register file write enable
- regfile_addr_wr  out  REG_ADDR_W  register file write address
- regfile_data_wr  out  DATA_W  register file write data
- hz_addr  in  REG_ADDR_W  hazard lookup register
- hz_pending  out  1  a live buffered write to hz_addr exists

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - FIFO empty; all entry valid bits 0; read/write pointers 0; count 0; starvation counter 0.
  - stall_req=0, lu_ready=1, hz_pending=0, regfile_wr=0.
- Port mux (combinational):
  - If pipe_wr=1, the regfile outputs equal the pipe inputs.
  - Else, if the FIFO is non-empty and the head entry is live, regfile_wr=1 with the head addr/data.
  - Otherwise regfile_wr=0.
- Pop: occurs when pipe_wr=0 and the FIFO is non-empty. A killed head is popped silently with regfile_wr=0 for it.
- Push:
  - lu_ready = !full, derived from registered count only (no combinational path from pipe_wr).
  - A handshake (lu_valid && lu_ready) stores {addr, data, live=1} at the tail.
  - If lu_addr==0, the result is accepted but not stored: no push, and count is unchanged.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: no push; lu_valid is held by the producer.
- Latency: minimum 1 cycle from handshake to regfile write (push at edge N, write in cycle N+1 if pipe_wr=0 then).
- WAW kill:
  - When pipe_wr=1 and pipe_addr!=0, every live FIFO entry with a matching addr has live cleared at the clock edge.
  - A result pushed in that same cycle is younger than the pipe write and is not killed.
- Hazard lookup:
  - hz_pending=1 iff hz_addr!=0 and any live entry matches, including the entry being pushed this cycle.
  - Combinational.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
- stall_req:
  - Registered. Set when the counter reaches STARVE_LIMIT.
  - Stays 1 until the cycle after a pop. Its next value is 0 when pop=1 that cycle.
  - The pipeline gates pipe_wr low while stalled, so the drain is guaranteed.
- Pointers wrap modulo FIFO_DEPTH. count uses $clog2(FIFO_DEPTH)+1 bits.
- Reset mid-operation discards all buffered results; the producer must not rely on them.

Decomposition:
- Shared defines header (existing): DATA_W, REG_ADDR_W. Add WBARB_FIFO_DEPTH and WBARB_STARVE_LIMIT as defaults.
- One natural sub-module: wb_result_fifo. It holds the storage, pointers, count and live bits, and provides parallel address compare outputs for kill and lookup.
- The arbiter top holds the mux, pop logic and starvation counter.

Test Plan:
- Reset, then lu push {r5, 0xAAAA0001} with pipe_wr=0 throughout -> next cycle regfile_wr=1, addr=5, data=0xAAAA0001; FIFO then empty.
- pipe_wr=1 to r3 continuously; push 4 results to r6..r9 -> lu_ready=0 after the 4th. After 8 waiting cycles stall_req=1; bench drops pipe_wr -> r6 written; stall_req=0 the following cycle.
- Push {r7, 0x11} while pipe_wr=1; next cycle pipe_wr=1 to r7 data 0x22 -> the entry is killed. Later idle cycle: pop with regfile_wr=0; r7 ends as 0x22.
- Push {r0, 0xFF} -> handshake completes, count stays 0, no regfile write ever, hz_pending for hz_addr=0 stays 0.
- FIFO full, pipe_wr=0, lu_valid=1 -> pop writes the head. lu_ready rises the next cycle; push and pop then occur together with count held at 3 or 4.
- Push {r12, x}; hz_addr=12 -> hz_pending=1 from the push cycle until the pop cycle. Assert rst mid-buffer -> hz_pending=0, lu_ready=1, no further writes.
